seg7_scan: RTL and testbench
============================

# seg7_scan

Parametrised multiplexed seven-segment display driver. It accepts a packed hex value plus decimal-point bits and scans them across `DIGITS` common-enable digits with a programmable refresh rate and an inter-digit blanking gap. Value updates are double-buffered and applied only at frame boundaries, so the display never shows a mixed old/new frame. It replaces the fixed 4-digit display logic in `top` and drives the `DS_EN*` and `DS_A..DS_G` pins.

## Interface
- `DIGITS`, 4: number of digits scanned (1..16).
- `DIV`, 1024: clock cycles per digit slot (≥ 4).
- `GAP`, 2: cycles at the end of each slot with all enables inactive (0 ≤ GAP < DIV).
- `SEG_ACTIVE_LOW`, 0: 1 inverts `DS_SEG` and `DS_DP` at the pins.
- `EN_ACTIVE_LOW`, 0: 1 inverts `DS_EN` at the pins.

Ports:
- `CLK`  in  1: single clock.
- `RST`  in  1: asynchronous, active-high reset.
- `DATA`  in  4*DIGITS: hex nibbles; nibble k = `DATA[4k+3:4k]` is shown on digit k, and digit 0 is least significant.
- `DP`  in  DIGITS: decimal-point bit per digit.
- `LOAD`  in  1: single-cycle strobe that captures `DATA`/`DP` into the shadow register.
- `DS_EN`  out  DIGITS: digit enables; bit k drives digit k.
- `DS_SEG`  out  7: segment outputs, bit 0 = A … bit 6 = G.
- `DS_DP`  out  1: decimal-point segment.
- `FRAME`  out  1: one-cycle pulse at each frame start.

## Operation
- **Prescaler** `pcnt` counts 0..DIV-1 and wraps. On `pcnt == DIV-1`, digit index `dig` advances by 1 modulo `DIGITS`.
- **Shadow register.** `LOAD` high writes `DATA`/`DP` into the shadow register and sets `pending`.
- **Frame boundary** is the cycle where `dig` wraps from DIGITS-1 to 0 (with DIGITS=1, every slot wrap is a boundary).
  - If `pending` is set, shadow is copied to active and `pending` clears.
  - `FRAME` pulses in the same cycle.
- **LOAD coincident with a boundary:** the boundary copies the old shadow. The new shadow is written and `pending` stays 1, so it is applied at the next boundary.
- **LOAD repeated before a boundary:** the last write wins.
- **Decode.** The active nibble for `dig` goes through the hex table, with active-high values:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - `DS_DP` is the active `DP[dig]`.
- **Enables.** `DS_EN` is one-hot on `dig` while `pcnt < DIV-GAP`; otherwise all inactive.
  - Segments may change only while all enables are inactive, or at the slot start when GAP=0.
- **Polarity** inversion is applied last, at the output registers.
- **Reset values:**
  - `pcnt`=0, `dig`=0, active=0, shadow=0, `pending`=0, `FRAME`=0.
  - `DS_EN` inactive, `DS_SEG` and `DS_DP` inactive (all off).
- **Reset mid-operation** aborts the current slot immediately and discards any pending value.

## Timing
- All outputs are registered: one cycle from counter state to pins.
- After `RST` deasserts:
  - The first enable (digit 0) appears on the first clock edge's output, at cycle 1.
  - Its segments show active=0, i.e. a blank digit is driven as "0" = 3F.
- Slot length is exactly DIV cycles, of which DIV-GAP cycles are enabled. Frame length is DIGITS*DIV cycles.
- Latency from `LOAD` to display is at most one frame plus one slot, and never less than the remainder of the current frame.
- `FRAME` is high for exactly 1 cycle per frame. It is registered and aligned with the first output cycle of digit 0's slot.

## Configuration
- The macro `SEG7_LZB_EN` enables leading-zero blanking.
- **Defined:**
  - Digits above the highest nonzero active nibble have `DS_SEG` forced off.
  - Digit 0 is never blanked, and the `DP` of a blanked digit still shows.
  - The blank mask is computed from the active register, so it changes only at frame boundaries.
- **Undefined:** all digits always decode, and the blanking logic is absent.

## Structure
- Package `seg7_pkg` holds:
  - the 16-entry hex-to-segment constant table;
  - segment bit-index constants `SEG_A..SEG_G`;
  - the `SEG_OFF` constant.
- Sub-module `seg7_decode` (combinational): nibble in, 7-bit active-high segments out.
- Scan counters, buffering, blanking and polarity live in `seg7_scan`.

## Test plan
All scenarios use DIGITS=4, DIV=8, GAP=2.
- **Reset.** Hold `RST` for 5 cycles, release.
  - During reset: all outputs off.
  - After release: `DS_EN`=0001 for 6 cycles, then off for 2, then 0010. `FRAME` pulses every 32 cycles.
- **Load.** `LOAD` with `DATA`=16'h1A3F, `DP`=4'b0100 mid-frame.
  - Nothing changes until the next `FRAME`.
  - Then digits 0..3 show 71, 4F, 77 with DP, and 06.
- **Coincident load.** Pulse `LOAD`=16'h0001 in the boundary cycle, with an earlier load of 16'h2222 pending.
  - That frame shows 2222.
  - The next frame shows 0001.
- **Double load.** Pulses 16'h1111 then 16'h5555 within one frame → only 5555 is ever displayed.
- **Polarity.** `SEG_ACTIVE_LOW`=1, `EN_ACTIVE_LOW`=1, `DATA`=16'h8888 → `DS_SEG`=7'h00 while enabled, and `DS_EN` bits are low when active.
- **Blanking** (`SEG7_LZB_EN`). `DATA`=16'h0050, `DP`=4'b1000.
  - Digits 3 and 2 have segments off, and digit 3 has DP on.
  - Digit 1 shows 6D, digit 0 shows 3F.
  - `DATA`=0 → digit 0 shows 3F.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
// Segment bit order is A (bit 0) through G (bit 6), all values active-high.
package seg7_pkg;

  // Segment bit positions inside a 7-bit segment word
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark (active-high encoding)
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex digit to segment pattern, index = nibble value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: value-load strobe and display pin bundle for seg7_scan.
// Handshake: LOAD is a one-cycle strobe with no ready/backpressure; the
// scanner always accepts DATA/DP in any cycle where LOAD is high, and the
// last strobe before a frame boundary is the one that gets displayed.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] DATA;
  logic [DIGITS-1:0]   DP;
  logic                LOAD;
  logic [DIGITS-1:0]   DS_EN;
  logic [6:0]          DS_SEG;
  logic                DS_DP;
  logic                FRAME;

  modport master (
    output DATA, DP, LOAD,
    input  DS_EN, DS_SEG, DS_DP, FRAME
  );

  modport slave (
    input  DATA, DP, LOAD,
    output DS_EN, DS_SEG, DS_DP, FRAME
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-high segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    seg_o = HEX_SEG[nib_i];
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment driver scanning DIGITS digits.
// New values are double-buffered (shadow -> active) and only switched at a
// frame boundary, so a frame never mixes old and new digits. All pin
// outputs are registered and carry the configured polarity.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 1024,
  parameter int GAP            = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit EN_ACTIVE_LOW  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  seg7_scan_if.slave  bus
);

  localparam int PW     = $clog2(DIV);
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW     = 4 * DIGITS;
  localparam int ON_CYC = DIV - GAP;

  // Pin levels that mean "off" under the chosen polarity
  localparam logic [DIGITS-1:0] EN_IDLE  = EN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]        SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_IDLE  = SEG_ACTIVE_LOW;

  // Scan counters
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [DW-1:0]     dig_q, dig_d;
  // Double buffer
  logic [NW-1:0]     shadow_q, shadow_d;
  logic [DIGITS-1:0] sdp_q, sdp_d;
  logic              pend_q, pend_d;
  logic [NW-1:0]     active_q, active_d;
  logic [DIGITS-1:0] adp_q, adp_d;
  // Output registers (already polarity-adjusted)
  logic [DIGITS-1:0] en_q, en_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_q, frame_d;

  logic              slot_end;
  logic              frame_end;
  logic              slot_on;
  logic [3:0]        nib;
  logic              dp_sel;
  logic [DIGITS-1:0] en_raw;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_vis;

  assign slot_end  = (pcnt_q == PW'(DIV - 1));
  assign frame_end = slot_end && (dig_q == DW'(DIGITS - 1));
  assign slot_on   = (int'(pcnt_q) < ON_CYC);

  // Prescaler and digit index advance
  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    dig_d  = dig_q;
    if (slot_end) begin
      pcnt_d = '0;
      dig_d  = frame_end ? '0 : dig_q + DW'(1);
    end
  end

  // Shadow capture and frame-boundary transfer; a LOAD in the boundary
  // cycle lands in shadow after the old shadow has been copied out.
  always_comb begin
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    pend_d   = pend_q;
    active_d = active_q;
    adp_d    = adp_q;
    if (frame_end && pend_q) begin
      active_d = shadow_q;
      adp_d    = sdp_q;
      pend_d   = 1'b0;
    end
    if (bus.LOAD) begin
      shadow_d = bus.DATA;
      sdp_d    = bus.DP;
      pend_d   = 1'b1;
    end
  end

  // Select the nibble, decimal point and enable for the current digit
  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    en_raw = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(dig_q) == k) begin
        nib       = active_q[4*k +: 4];
        dp_sel    = adp_q[k];
        en_raw[k] = slot_on;
      end
    end
  end

  seg7_decode u_decode (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] lzb_mask;
  logic              lzb_nz;
  logic              lzb_blank;

  // Leading-zero mask from the active value: a digit is dark when it and
  // every digit above it are zero; digit 0 always shows.
  always_comb begin
    lzb_nz   = 1'b0;
    lzb_mask = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lzb_nz      = lzb_nz | (|active_q[4*k +: 4]);
      lzb_mask[k] = (k != 0) && !lzb_nz;
    end
  end

  // Blank flag for the digit currently being scanned
  always_comb begin
    lzb_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(dig_q) == k) lzb_blank = lzb_mask[k];
    end
  end

  assign seg_vis = lzb_blank ? SEG_OFF : dec_seg;
`else
  assign seg_vis = dec_seg;
`endif

  // Output next-state with polarity applied last
  always_comb begin
    en_d    = EN_ACTIVE_LOW ? ~en_raw : en_raw;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_vis : seg_vis;
    dp_d    = SEG_ACTIVE_LOW ? ~dp_sel : dp_sel;
    frame_d = (pcnt_q == '0) && (dig_q == '0);
  end

  // State and output registers; reset aborts the slot and drops pending data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt_q   <= '0;
      dig_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      pend_q   <= 1'b0;
      active_q <= '0;
      adp_q    <= '0;
      en_q     <= EN_IDLE;
      seg_q    <= SEG_IDLE;
      dp_q     <= DP_IDLE;
      frame_q  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      adp_q    <= adp_d;
      en_q     <= en_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.DS_EN  = en_q;
  assign bus.DS_SEG = seg_q;
  assign bus.DS_DP  = dp_q;
  assign bus.FRAME  = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: bench for seg7_scan with DIGITS=4, DIV=8, GAP=2.
// Two instances share stimulus: one with active-high pins, one with both
// polarities inverted. A cycle model pushes the expected pin word at each
// clock edge; it is popped and compared on the following falling edge.
`timescale 1ns/1ps
module tb_seg7_scan;

  localparam int DIGITS    = 4;
  localparam int DIV       = 8;
  localparam int GAP       = 2;
  localparam int FRAME_LEN = DIGITS * DIV;

  // Pin word layout: {FRAME, DS_EN[3:0], DS_SEG[6:0], DS_DP}
  localparam logic [12:0] OFF     = 13'h0000;
  localparam logic [12:0] OFF_INV = {1'b0, 4'hF, 7'h7F, 1'b1};
  localparam logic [12:0] INV_MSK = 13'h0FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [12:0] exp_q[$];

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();
  seg7_scan_if #(.DIGITS(DIGITS)) bus_n ();

  assign bus_n.DATA = bus.DATA;
  assign bus_n.DP   = bus.DP;
  assign bus_n.LOAD = bus.LOAD;

  seg7_scan #(
    .DIGITS(DIGITS), .DIV(DIV), .GAP(GAP),
    .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  seg7_scan #(
    .DIGITS(DIGITS), .DIV(DIV), .GAP(GAP),
    .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
  ) u_dut_n (
    .CLK (clk),
    .RST (rst),
    .bus (bus_n)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Reference model: m_t counts clock edges since reset release
  int          m_t    = 0;
  logic [15:0] m_sh   = '0;
  logic [15:0] m_act  = '0;
  logic [3:0]  m_sdp  = '0;
  logic [3:0]  m_adp  = '0;
  logic        m_pend = 1'b0;

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_t = 0; m_sh = '0; m_act = '0; m_sdp = '0; m_adp = '0; m_pend = 1'b0;
      end else begin : step
        int          pc;
        int          dg;
        logic [6:0]  sg;
        logic [3:0]  en;
        logic [12:0] e;
        pc = m_t % DIV;
        dg = (m_t / DIV) % DIGITS;
        sg = hex7(m_act[4*dg +: 4]);
`ifdef SEG7_LZB_EN
        if (dg != 0 && (m_act >> (4*dg)) == 16'h0) sg = 7'h00;
`endif
        en = (pc < DIV - GAP) ? 4'(1 << dg) : 4'h0;
        e  = {((m_t % FRAME_LEN) == 0), en, sg, m_adp[dg]};
        if ((m_t % FRAME_LEN) == FRAME_LEN - 1 && m_pend) begin
          m_act = m_sh; m_adp = m_sdp; m_pend = 1'b0;
        end
        if (bus.LOAD) begin
          m_sh = bus.DATA; m_sdp = bus.DP; m_pend = 1'b1;
        end
        m_t++;
        exp_q.push_back(e);
      end
    end
  end

  // Scoreboard: compare both instances on every falling edge
  initial begin : scoreboard
    logic [12:0] obs, obs_n, e;
    forever begin
      @(negedge clk);
      obs   = {bus.FRAME, bus.DS_EN, bus.DS_SEG, bus.DS_DP};
      obs_n = {bus_n.FRAME, bus_n.DS_EN, bus_n.DS_SEG, bus_n.DS_DP};
      if (rst || exp_q.size() == 0) begin
        exp_q.delete();
        check_val("idle_out", 32'(obs), 32'(OFF));
        check_val("idle_inv", 32'(obs_n), 32'(OFF_INV));
      end else begin
        e = exp_q.pop_front();
        check_val("out", 32'(obs), 32'(e));
        check_val("inv_out", 32'(obs_n), 32'(e ^ INV_MSK));
      end
    end
  end

  // Driver: called #1 after a rising edge, returns #1 after the next one
  task automatic load(input logic [15:0] d, input logic [3:0] p);
    bus.DATA = d;
    bus.DP   = p;
    bus.LOAD = 1'b1;
    @(posedge clk); #1;
    bus.LOAD = 1'b0;
  endtask

  // Returns on the falling edge of the next FRAME-high cycle (bounded)
  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN && !seen; i++) begin
      @(negedge clk);
      seen = (bus.FRAME === 1'b1);
    end
    check_val("frame_seen", 32'(seen), 32'd1);
  endtask

  // Check the first enabled cycle of every digit in the next frame
  task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] e_en, e_en_n;
    logic [6:0] e_seg, e_seg_n;
    logic       e_dp_n;
    wait_frame();
    for (int k = 0; k < DIGITS; k++) begin
      if (k > 0) repeat (DIV) @(negedge clk);
      e_en    = 4'(1 << k);
      e_en_n  = ~e_en;
      e_seg   = segs[7*k +: 7];
      e_seg_n = ~e_seg;
      e_dp_n  = ~dps[k];
      check_val($sformatf("dig%0d_en", k), 32'(bus.DS_EN), 32'(e_en));
      check_val($sformatf("dig%0d_seg", k), 32'(bus.DS_SEG), 32'(e_seg));
      check_val($sformatf("dig%0d_dp", k), 32'(bus.DS_DP), 32'(dps[k]));
      check_val($sformatf("dig%0d_en_n", k), 32'(bus_n.DS_EN), 32'(e_en_n));
      check_val($sformatf("dig%0d_seg_n", k), 32'(bus_n.DS_SEG), 32'(e_seg_n));
      check_val($sformatf("dig%0d_dp_n", k), 32'(bus_n.DS_DP), 32'(e_dp_n));
    end
  endtask

  logic [3:0] en_seq [9] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2};

  initial begin : stimulus
    int period;
    bus.DATA = '0;
    bus.DP   = '0;
    bus.LOAD = 1'b0;

    // Reset and scan start-up
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_val($sformatf("startup_en%0d", i), 32'(bus.DS_EN), 32'(en_seq[i]));
      if (i == 0) check_val("startup_frame", 32'(bus.FRAME), 32'd1);
    end
    wait_frame();
    period = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      @(negedge clk);
      period++;
      if (bus.FRAME === 1'b1) break;
    end
    check_val("frame_period", 32'(period), 32'(FRAME_LEN));

    // Mid-frame load shows from the next frame on
    wait_frame();
    repeat (10) @(posedge clk); #1;
    load(16'h1A3F, 4'b0100);
    check_frame({7'h06, 7'h77, 7'h4F, 7'h71}, 4'b0100);

    // Load in the boundary cycle while another value is pending
    wait_frame();
    @(posedge clk); #1;
    load(16'h2222, 4'b0000);
    repeat (28) @(posedge clk); #1;
    load(16'h0001, 4'b0000);
    check_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);
`ifdef SEG7_LZB_EN
    check_frame({7'h00, 7'h00, 7'h00, 7'h06}, 4'b0000);
`else
    check_frame({7'h3F, 7'h3F, 7'h3F, 7'h06}, 4'b0000);
`endif

    // Two loads inside one frame: last one wins
    wait_frame();
    @(posedge clk); #1;
    load(16'h1111, 4'b0000);
    load(16'h5555, 4'b0000);
    check_frame({7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b0000);

    // All segments on (inverted instance drives 7'h00)
    @(posedge clk); #1;
    load(16'h8888, 4'b0000);
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000);

    // Leading zeros
    @(posedge clk); #1;
    load(16'h0050, 4'b1000);
`ifdef SEG7_LZB_EN
    check_frame({7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b1000);
`else
    check_frame({7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b1000);
`endif
    @(posedge clk); #1;
    load(16'h0000, 4'b0000);
`ifdef SEG7_LZB_EN
    check_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
`else
    check_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
`endif

    // Random loads at random times, checked by the cycle model
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 70)) @(posedge clk);
      #1;
      load(16'($urandom), 4'($urandom));
    end
    repeat (2 * FRAME_LEN) @(posedge clk);
    #1;

    // Reset mid-slot discards a pending value
    load(16'h9876, 4'hF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
`ifdef SEG7_LZB_EN
    check_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
`else
    check_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
